// File: rtl/comp_bist.sv
// Built-in self test for a 4-bit magnitude comparator: sweeps all 256 operand
// pairs and counts flag mismatches. Optional first-failure capture: COMP_BIST_FAIL_CAPTURE_EN.
module comp_bist #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic [0:3] a_out,
  output logic [0:3] b_out,
  input  logic       less_in,
  input  logic       greater_in,
  input  logic       eq_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] err_cnt
`ifdef COMP_BIST_FAIL_CAPTURE_EN
  ,
  output logic       fail_valid,
  output logic [0:3] fail_a,
  output logic [0:3] fail_b,
  output logic [0:2] fail_flags
`endif
);

  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [7:0] idx;
  logic [3:0] wait_cnt;
  logic [7:0] idx_next;
  logic [8:0] err_next;
  logic [2:0] expected;
  logic [2:0] observed;
  logic       mismatch;

  // Expected flags come from the registered operands, which are stable for the
  // whole DRIVE/WAIT/CHECK window of a vector.
  always_comb begin
    idx_next = idx + 8'd1;
    expected = {a_out < b_out, a_out > b_out, a_out == b_out};
    observed = {less_in, greater_in, eq_in};
    mismatch = (observed != expected);
    err_next = mismatch ? err_cnt + 9'd1 : err_cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= 8'd0;
      wait_cnt <= 4'd0;
      a_out    <= 4'd0;
      b_out    <= 4'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= 9'd0;
`ifdef COMP_BIST_FAIL_CAPTURE_EN
      fail_valid <= 1'b0;
      fail_a     <= 4'd0;
      fail_b     <= 4'd0;
      fail_flags <= 3'd0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start && !abort) begin
            state   <= DRIVE;
            idx     <= 8'd0;
            a_out   <= 4'd0;
            b_out   <= 4'd0;
            err_cnt <= 9'd0;
            busy    <= 1'b1;
            done    <= 1'b0;
            pass    <= 1'b0;
`ifdef COMP_BIST_FAIL_CAPTURE_EN
            fail_valid <= 1'b0;
            fail_a     <= 4'd0;
            fail_b     <= 4'd0;
            fail_flags <= 3'd0;
`endif
          end
        end
        DRIVE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (SETTLE_CYCLES == 0) begin
            state <= CHECK;
          end else begin
            state    <= WAIT;
            wait_cnt <= SETTLE_LAST;
          end
        end
        WAIT: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (wait_cnt == 4'd0) begin
            state <= CHECK;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        CHECK: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            err_cnt <= err_next;
`ifdef COMP_BIST_FAIL_CAPTURE_EN
            if (mismatch && !fail_valid) begin
              fail_valid <= 1'b1;
              fail_a     <= a_out;
              fail_b     <= b_out;
              fail_flags <= observed;
            end
`endif
            // Operands for the next vector are loaded on the same edge that enters DRIVE.
            if (idx == 8'hFF) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == 9'd0);
            end else begin
              state <= DRIVE;
              idx   <= idx_next;
              a_out <= idx_next[7:4];
              b_out <= idx_next[3:0];
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comp_bist.sv
// Self-checking bench for comp_bist: a behavioural comparator with selectable
// faults feeds the DUT; expected counts come from a whole-sweep reference model.
module tb_comp_bist;

  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  logic [0:3] a_out, b_out;
  logic       less_in, greater_in, eq_in;
  logic       busy, done, pass;
  logic [8:0] err_cnt;
`ifdef COMP_BIST_FAIL_CAPTURE_EN
  logic       fail_valid;
  logic [0:3] fail_a, fail_b;
  logic [0:2] fail_flags;
`endif

  int checks = 0;
  int passed = 0;

  // 0 = correct, 1 = greater stuck 0, 2 = eq stuck 1, 3 = random fault table
  int         mode = 0;
  logic [2:0] fault_tab [256];
  logic [2:0] dut_flags;

  comp_bist #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a_out(a_out), .b_out(b_out),
    .less_in(less_in), .greater_in(greater_in), .eq_in(eq_in),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt)
`ifdef COMP_BIST_FAIL_CAPTURE_EN
    , .fail_valid(fail_valid), .fail_a(fail_a), .fail_b(fail_b), .fail_flags(fail_flags)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] ideal(int a, int b);
    return {a < b, a > b, a == b};
  endfunction

  function automatic logic [2:0] ref_flags(int m, int a, int b);
    logic [2:0] f;
    f = ideal(a, b);
    case (m)
      1: f[1] = 1'b0;
      2: f[0] = 1'b1;
      3: f = fault_tab[a*16 + b];
      default: ;
    endcase
    return f;
  endfunction

  // Comparator under test seen by the DUT
  always_comb begin
    dut_flags = {a_out < b_out, a_out > b_out, a_out == b_out};
    case (mode)
      1: dut_flags[1] = 1'b0;
      2: dut_flags[0] = 1'b1;
      3: dut_flags = fault_tab[{a_out, b_out}];
      default: ;
    endcase
  end
  assign {less_in, greater_in, eq_in} = dut_flags;

  // Reference: number of failing vectors with index below 'limit', and the first one
  function automatic int ref_errors(int m, int limit, output int first_idx);
    int n = 0;
    first_idx = -1;
    for (int i = 0; i < limit; i++) begin
      if (ref_flags(m, i / 16, i % 16) != ideal(i / 16, i % 16)) begin
        if (first_idx < 0) first_idx = i;
        n++;
      end
    end
    return n;
  endfunction

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
  endtask

  task automatic wait_vec(input logic [7:0] v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ({a_out, b_out} == v) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Cycles from DRIVE entry to done, or -1 on timeout
  task automatic wait_done(output int k);
    k = 0;
    while (!done && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (!done) k = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({a_out, b_out} !== 8'h00) $display("[TB] FAIL reset_operands got %h want 00", {a_out, b_out});
    else passed++;
    checks++;
    if ({busy, done, pass} !== 3'b000) $display("[TB] FAIL reset_status got %b want 000", {busy, done, pass});
    else passed++;
    checks++;
    if (err_cnt !== 9'd0) $display("[TB] FAIL reset_err_cnt got %0d want 0", err_cnt);
    else passed++;
  endtask

  task automatic test_full_pass();
    int k;
    mode = 0;
    pulse_start();
    checks++;
    if (busy !== 1'b1) $display("[TB] FAIL pass_busy got %b want 1", busy);
    else passed++;
    wait_done(k);
    checks++;
    if (k != 768) $display("[TB] FAIL pass_latency got %0d want 768", k);
    else passed++;
    checks++;
    if ({busy, done, pass} !== 3'b011) $display("[TB] FAIL pass_status got %b want 011", {busy, done, pass});
    else passed++;
    checks++;
    if (err_cnt !== 9'd0) $display("[TB] FAIL pass_err_cnt got %0d want 0", err_cnt);
    else passed++;
  endtask

  task automatic test_stuck_greater();
    int k;
    mode = 1;
    pulse_start();
    wait_done(k);
    checks++;
    if (k != 768) $display("[TB] FAIL stuck_gt_latency got %0d want 768", k);
    else passed++;
    checks++;
    if (err_cnt !== 9'd120) $display("[TB] FAIL stuck_gt_err_cnt got %0d want 120", err_cnt);
    else passed++;
    checks++;
    if ({done, pass} !== 2'b10) $display("[TB] FAIL stuck_gt_pass got %b want 10", {done, pass});
    else passed++;
`ifdef COMP_BIST_FAIL_CAPTURE_EN
    checks++;
    if ({fail_valid, fail_a, fail_b, fail_flags} !== {1'b1, 4'b0001, 4'b0000, 3'b000})
      $display("[TB] FAIL stuck_gt_capture got %b %b %b %b want 1 0001 0000 000", fail_valid, fail_a, fail_b, fail_flags);
    else passed++;
`endif
  endtask

  task automatic test_stuck_eq();
    int k;
    mode = 2;
    pulse_start();
    wait_done(k);
    checks++;
    if (err_cnt !== 9'd240 || done !== 1'b1) $display("[TB] FAIL stuck_eq_err_cnt got %0d done %b want 240 done 1", err_cnt, done);
    else passed++;
    checks++;
    if (pass !== 1'b0) $display("[TB] FAIL stuck_eq_pass got %b want 0", pass);
    else passed++;
  endtask

  task automatic test_vector_9d();
    bit ok;
    mode = 0;
    pulse_start();
    wait_vec(8'h9D, ok);
    checks++;
    if (!ok) $display("[TB] FAIL vec9d_reach got timeout want 9d");
    else passed++;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_out, b_out, less_in, greater_in, eq_in} !== {8'h9D, 3'b100})
      $display("[TB] FAIL vec9d_check got %h/%b want 9d/100", {a_out, b_out}, {less_in, greater_in, eq_in});
    else passed++;
    @(negedge clk);
    checks++;
    if ({a_out, b_out} !== 8'h9E || err_cnt !== 9'd0)
      $display("[TB] FAIL vec9d_next got %h err %0d want 9e err 0", {a_out, b_out}, err_cnt);
    else passed++;
    pulse_abort();
  endtask

  task automatic test_abort();
    bit ok;
    int first, exp_err;
    mode = 2;
    exp_err = ref_errors(2, 8'h40, first);
    pulse_start();
    wait_vec(8'h40, ok);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    checks++;
    if (!ok || {busy, done} !== 2'b00) $display("[TB] FAIL abort_status got %b reached %0d want 00", {busy, done}, ok);
    else passed++;
    checks++;
    if ({a_out, b_out} !== 8'h40 || err_cnt !== 9'(exp_err))
      $display("[TB] FAIL abort_hold got %h err %0d want 40 err %0d", {a_out, b_out}, err_cnt, exp_err);
    else passed++;
    pulse_start();
    checks++;
    if ({a_out, b_out} !== 8'h00 || err_cnt !== 9'd0 || busy !== 1'b1)
      $display("[TB] FAIL abort_restart got %h err %0d busy %b want 00 0 1", {a_out, b_out}, err_cnt, busy);
    else passed++;
    pulse_abort();
  endtask

  task automatic test_start_abort_idle();
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) $display("[TB] FAIL start_abort_idle got %b want 00", {busy, done});
    else passed++;
  endtask

  task automatic test_start_during_busy();
    bit ok;
    mode = 0;
    pulse_start();
    wait_vec(8'h20, ok);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || {a_out, b_out} !== 8'h21 || busy !== 1'b1)
      $display("[TB] FAIL start_busy_idx got %h busy %b want 21 1", {a_out, b_out}, busy);
    else passed++;
    pulse_abort();
  endtask

  task automatic test_random_faults();
    int k, first, exp_err;
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < 256; i++) begin
        fault_tab[i] = ideal(i / 16, i % 16);
        if ($urandom_range(7) == 0) fault_tab[i] = 3'($urandom_range(7));
      end
      mode = 3;
      exp_err = ref_errors(3, 256, first);
      pulse_start();
      wait_done(k);
      checks++;
      if (k != 768 || err_cnt !== 9'(exp_err))
        $display("[TB] FAIL rand_err_cnt got %0d cycles %0d want %0d cycles 768", err_cnt, k, exp_err);
      else passed++;
      checks++;
      if (pass !== (exp_err == 0)) $display("[TB] FAIL rand_pass got %b want %b", pass, exp_err == 0);
      else passed++;
`ifdef COMP_BIST_FAIL_CAPTURE_EN
      checks++;
      if (first < 0) begin
        if (fail_valid !== 1'b0) $display("[TB] FAIL rand_capture got valid %b want 0", fail_valid);
        else passed++;
      end else if ({fail_valid, fail_a, fail_b, fail_flags} !== {1'b1, 8'(first), fault_tab[first]})
        $display("[TB] FAIL rand_capture got %b %h%h %b want 1 %h %b",
                 fail_valid, fail_a, fail_b, fail_flags, 8'(first), fault_tab[first]);
      else passed++;
`endif
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    mode = 2;
    pulse_start();
    wait_vec(8'h30, ok);
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk) begin rst_n = 1'b1; start = 1'b0; end
    checks++;
    if (!ok || {a_out, b_out, busy, done, pass} !== 11'd0 || err_cnt !== 9'd0)
      $display("[TB] FAIL reset_mid got %h %b err %0d want all 0", {a_out, b_out}, {busy, done, pass}, err_cnt);
    else passed++;
`ifdef COMP_BIST_FAIL_CAPTURE_EN
    checks++;
    if (fail_valid !== 1'b0) $display("[TB] FAIL reset_mid_capture got %b want 0", fail_valid);
    else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_stuck_greater();
    test_stuck_eq();
    test_vector_9d();
    test_abort();
    test_start_abort_idle();
    test_start_during_busy();
    test_random_faults();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/comp_bist.md
COMP_BIST -- requirements
Module: comp_bist

Interface
REQ-001 SHALL provide parameter: SETTLE_CYCLES, 1, idle cycles between operand drive and flag sample (0..15).
REQ-002 SHALL provide ports: clk  input  1  sole clock, rising edge.
REQ-003 SHALL provide ports: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL provide ports: start  input  1  single-cycle request to begin a sweep.
REQ-005 SHALL provide ports: abort  input  1  cancel a sweep in progress.
REQ-006 SHALL provide ports: a_out  output  [0:3]  operand A to the comparator under test, bit 0 = MSB.
REQ-007 SHALL provide ports: b_out  output  [0:3]  operand B to the comparator under test, bit 0 = MSB.
REQ-008 SHALL provide ports: less_in, greater_in, eq_in  input  1 each  result flags from the comparator under test.
REQ-009 SHALL provide ports: busy  output  1  sweep in progress.
REQ-010 SHALL provide ports: done  output  1  sweep completed; held until next accepted start or reset.
REQ-011 SHALL provide ports: pass  output  1  done and err_cnt == 0.
REQ-012 SHALL provide ports: err_cnt  output  9  count of failing vectors in the current or last sweep.

Function
REQ-013 SHALL implement FSM states IDLE, DRIVE, WAIT, CHECK, DONE.
REQ-014 SHALL use an 8-bit vector index idx; a_out = idx[7:4], b_out = idx[3:0], unsigned.
REQ-015 SHALL, in IDLE or DONE, on start=1 and abort=0: clear idx, err_cnt, done; go to DRIVE next cycle.
REQ-016 SHALL register a_out/b_out from idx on DRIVE entry; outputs stable through WAIT and CHECK.
REQ-017 SHALL stay in WAIT exactly SETTLE_CYCLES cycles; SETTLE_CYCLES=0 goes DRIVE->CHECK directly.
REQ-018 SHALL in CHECK compare {less_in,greater_in,eq_in} to expected {a<b, a>b, a==b}; any mismatch, including multiple or zero flags asserted, increments err_cnt by 1.
REQ-019 SHALL in CHECK go to DRIVE with idx+1 if idx != 255, else to DONE; per-vector period = SETTLE_CYCLES+2 cycles.
REQ-020 SHALL assert busy in DRIVE, WAIT, CHECK only; assert done in DONE only.
REQ-021 SHALL ignore start while busy.
REQ-022 SHALL, on abort=1 while busy, go to IDLE next cycle; done stays 0, err_cnt and operands hold their values.
REQ-023 SHALL give abort priority over start when both are asserted in the same cycle.
REQ-024 SHALL not wrap or saturate err_cnt; its maximum is 256.

Reset
REQ-025 SHALL, on rst_n=0 at a clock edge, enter IDLE with a_out=0, b_out=0, idx=0, err_cnt=0, busy=0, done=0, pass=0.
REQ-026 SHALL let reset mid-sweep override all other inputs; no partial result is retained.

Configuration
REQ-027 SHALL support macro COMP_BIST_FAIL_CAPTURE_EN; when defined, add outputs fail_valid (1), fail_a [0:3], fail_b [0:3], fail_flags [0:2] ({less,greater,eq}) recording the first failing vector of a sweep, cleared by reset and accepted start.
REQ-028 SHALL, without COMP_BIST_FAIL_CAPTURE_EN, omit these ports and registers; all other behaviour is identical.

Verification
REQ-029 SHALL cover: correct comparator model, SETTLE_CYCLES=1, start pulse -> done=1, pass=1, err_cnt=0 exactly 768 cycles after DRIVE entry.
REQ-030 SHALL cover: greater_in stuck at 0 -> err_cnt=120, pass=0; with the macro, fail_a=0001, fail_b=0000, fail_flags=000.
REQ-031 SHALL cover: eq_in stuck at 1 -> err_cnt=240 at done.
REQ-032 SHALL cover: idx=0x9D (a=1001, b=1101) with a correct model -> flags 100 sampled in CHECK, no error increment.
REQ-033 SHALL cover: abort at idx=0x40 -> busy=0 next cycle, done=0; a following start restarts at idx=0 with err_cnt=0.
REQ-034 SHALL cover: start and abort together in IDLE -> stays IDLE; start during busy -> idx unaffected; rst_n=0 mid-sweep -> all outputs 0 next cycle.
